// File: rtl/pipe_drain_buffer.sv
// ============================================================================
// pipe_drain_buffer : tail FIFO of an enable-gated pipeline with a stall-safe
// advance enable. Optional stall counter is enabled by DRAIN_STALL_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_drain_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         pipe_en,
  output logic                         m_valid,
  output logic [DATA_WIDTH-1:0]        m_data,
  input  logic                         m_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef DRAIN_STALL_CNT_EN
  ,
  output logic [31:0]                  stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] C_FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (count_q == C_FULL_CNT);
  assign w_empty = (count_q == '0);

  assign m_valid = ~w_empty;
  assign m_data  = mem_q[rd_ptr_q];
  assign count   = count_q;

  assign w_pop   = m_valid & m_ready;
  // Advance only when any word emerging this cycle is guaranteed a slot.
  assign pipe_en = ~rst & (~w_full | w_pop);
  assign w_push  = s_valid & pipe_en;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (w_push && !w_pop) begin
      count_d = count_q + CW'(1);
    end else if (w_pop && !w_push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

`ifdef DRAIN_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pipe_en && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_drain_buffer.sv
// ============================================================================
// tb_pipe_drain_buffer : directed self-checking bench for pipe_drain_buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_drain_buffer;

  localparam int DATA_WIDTH = 16;
  localparam int DEPTH      = 4;
  localparam int CW         = $clog2(DEPTH+1);

  logic                  clk;
  logic                  rst;
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  pipe_en;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;
  logic [CW-1:0]         count;
`ifdef DRAIN_STALL_CNT_EN
  logic [31:0]           stall_cnt;
`endif

  int n_total;
  int n_pass;

  pipe_drain_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .pipe_en   (pipe_en),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .count     (count)
`ifdef DRAIN_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int out_k;
    int in_k;
    int cyc;
    n_total = 0;
    n_pass  = 0;

    // Reset then idle
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    tick(); tick();
    chk("rst_pipe_en", 32'(pipe_en), 32'd0);
    chk("rst_count",   32'(count),   32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
`ifdef DRAIN_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("idle_pipe_en", 32'(pipe_en), 32'd1);
    tick();
    chk("idle_count",   32'(count),   32'd0);
    chk("idle_m_valid", 32'(m_valid), 32'd0);

    // Pass-through with consumer always ready
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 16'h0001;
    #1; chk("pt_pipe_en0", 32'(pipe_en), 32'd1);
    tick();
    chk("pt_m_data1", 32'(m_data), 32'h0001);
    chk("pt_count1",  32'(count),  32'd1);
    s_data = 16'h0002;
    #1; chk("pt_pipe_en1", 32'(pipe_en), 32'd1);
    tick();
    chk("pt_m_data2", 32'(m_data), 32'h0002);
    chk("pt_count2",  32'(count),  32'd1);
    s_data = 16'h0003;
    #1; chk("pt_pipe_en2", 32'(pipe_en), 32'd1);
    tick();
    chk("pt_m_data3", 32'(m_data), 32'h0003);
    chk("pt_count3",  32'(count),  32'd1);
    s_valid = 1'b0;
    tick();
    chk("pt_drained_valid", 32'(m_valid), 32'd0);
    chk("pt_drained_count", 32'(count),   32'd0);

    // Fill and stall
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 16'h00A0 + 16'(i);
      tick();
    end
    chk("fill_count",  32'(count),  32'd4);
    chk("fill_m_data", 32'(m_data), 32'h00A0);
    s_data = 16'h00A4;
    #1; chk("fill_pipe_en", 32'(pipe_en), 32'd0);
    tick();
    chk("stall_count1", 32'(count),  32'd4);
    chk("stall_m_data", 32'(m_data), 32'h00A0);
    tick();
    chk("stall_count2",   32'(count),   32'd4);
    chk("stall_pipe_en",  32'(pipe_en), 32'd0);
`ifdef DRAIN_STALL_CNT_EN
    chk("stall_cnt_fill", stall_cnt, 32'd2);
`endif

    // Full with simultaneous push and pop
    m_ready = 1'b1;
    #1; chk("full_pp_pipe_en", 32'(pipe_en), 32'd1);
    tick();
    chk("full_pp_count",  32'(count),  32'd4);
    chk("full_pp_m_data", 32'(m_data), 32'h00A1);
    s_valid = 1'b0;
    tick();
    chk("drain_a2", 32'(m_data), 32'h00A2);
    tick();
    chk("drain_a3", 32'(m_data), 32'h00A3);
    tick();
    chk("drain_a4", 32'(m_data), 32'h00A4);
    chk("drain_cnt1", 32'(count), 32'd1);
    tick();
    chk("drain_empty", 32'(m_valid), 32'd0);

    // Wrap-around: 10 words with toggling ready
    in_k = 0; out_k = 0; cyc = 0;
    while (out_k < 10 && cyc < 200) begin
      m_ready = (cyc % 2 == 0);
      s_valid = (in_k < 10);
      s_data  = 16'h0100 + 16'(in_k);
      #1;
      if (m_valid && m_ready) begin
        chk("wrap_order", 32'(m_data), 32'h0100 + 32'(out_k));
        out_k++;
      end
      if (pipe_en && s_valid) in_k++;
      tick();
      cyc++;
    end
    chk("wrap_out_total", 32'(out_k), 32'd10);
    s_valid = 1'b0; m_ready = 1'b0;
    #1;
    chk("wrap_final_count", 32'(count), 32'd0);

    // Reset mid-operation with three stored words
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 16'h0200 + 16'(i);
      tick();
    end
    s_valid = 1'b0;
    chk("mid_count3", 32'(count), 32'd3);
    rst = 1'b1;
    tick();
    chk("mid_rst_count",   32'(count),   32'd0);
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
`ifdef DRAIN_STALL_CNT_EN
    chk("mid_rst_stall_cnt", stall_cnt, 32'd0);
`endif
    rst = 1'b0;
    s_valid = 1'b1; s_data = 16'h0BEE;
    tick();
    s_valid = 1'b0;
    chk("post_rst_m_valid", 32'(m_valid), 32'd1);
    chk("post_rst_m_data",  32'(m_data),  32'h0BEE);
    chk("post_rst_count",   32'(count),   32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
